prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameters: ADDR_W, default 4, RAM address width; DATA_W, default 8, RAM word width.
REQ-002 SHALL have ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- LOAD_REQ  in  1  level; high requests program-load mode
- DIN  in  DATA_W  program byte from external host
- DIN_VALID  in  1  DIN holds a byte
- DIN_READY  out  1  loader accepts DIN this cycle
- CPU_T1  in  1  controller ring counter is at T1 (instruction boundary)
- CPU_ADDR  in  ADDR_W  CPU memory-address-register value
- MEM_ADDR  out  ADDR_W  address to RAM
- MEM_WDATA  out  DATA_W  write data to RAM
- MEM_WE  out  1  RAM write enable, sampled on CLK rising edge
- CPU_HALT  out  1  freezes controller/PC/registers
- CPU_RST  out  1  one-cycle reset pulse to PC, IR, A, B, controller
- LOAD_DONE  out  1  last load completed
- BYTE_CNT  out  ADDR_W+1  bytes written in current/last load

Function
REQ-003 SHALL implement FSM states IDLE, WAIT_T1, LOAD, RELEASE; state, address counter, BYTE_CNT, LOAD_DONE registered.
REQ-004 IDLE: CPU owns RAM; MEM_ADDR=CPU_ADDR, MEM_WE=0, CPU_HALT=0, DIN_READY=0; DIN_VALID ignored.
REQ-005 IDLE -> WAIT_T1 when LOAD_REQ=1; on this transition address counter and BYTE_CNT clear to 0, LOAD_DONE clears to 0.
REQ-006 WAIT_T1: CPU keeps running, CPU_HALT=0; -> LOAD on first edge with CPU_T1=1 and LOAD_REQ=1; -> IDLE if LOAD_REQ=0 (abort; no halt, no CPU_RST, LOAD_DONE stays 0).
REQ-007 LOAD: CPU_HALT=1, DIN_READY=1, MEM_ADDR=address counter, MEM_WDATA=DIN, MEM_WE=DIN_VALID (combinational, same cycle).
REQ-008 Each LOAD cycle with DIN_VALID=1 SHALL write one byte; address counter +1 modulo 2^ADDR_W, BYTE_CNT +1.
REQ-009 LOAD -> RELEASE on the edge writing byte 2^ADDR_W (BYTE_CNT reaches 16, address wraps to 0), or when LOAD_REQ=0; if both, the byte is still written.
REQ-010 After BYTE_CNT=2^ADDR_W, no further write SHALL occur in that load even with LOAD_REQ=1.
REQ-011 RELEASE (exactly one cycle): CPU_HALT=1, CPU_RST=1, MEM_WE=0, DIN_READY=0; LOAD_DONE set to 1 on exit; -> IDLE.
REQ-012 From RELEASE, IDLE SHALL wait for LOAD_REQ to be low at least one cycle before re-entering WAIT_T1 (level held high does not retrigger).
REQ-013 CPU_RST SHALL be high only in RELEASE; CPU_HALT only in LOAD and RELEASE.
REQ-014 Zero-byte load (LOAD_REQ drops in LOAD before any DIN_VALID) SHALL still pass RELEASE, BYTE_CNT=0, LOAD_DONE=1.
REQ-015 BYTE_CNT and LOAD_DONE SHALL hold their values in IDLE until next load start.

Reset
REQ-016 RST=1 SHALL immediately force IDLE, address counter 0, BYTE_CNT 0, LOAD_DONE 0, CPU_HALT 0, CPU_RST 0, MEM_WE 0, DIN_READY 0, regardless of state.
REQ-017 RST during LOAD SHALL abort without CPU_RST pulse; RAM bytes already written remain.
REQ-018 After RST release, LOAD_REQ already high SHALL start a load (re-arm rule of REQ-012 cleared by reset).

Verification
REQ-019 Full load: LOAD_REQ=1, CPU_T1 pulses, 16 bytes 0x10..0x1F with DIN_VALID=1 -> writes addr 0..15, BYTE_CNT=16, one-cycle CPU_RST, LOAD_DONE=1, CPU_HALT low afterwards.
REQ-020 Gapped stream: DIN_VALID toggling 1,0,1 with bytes 0xA5,0x3C -> MEM_WE only on valid cycles, addr 0 and 1 written, BYTE_CNT=2 after LOAD_REQ drop.
REQ-021 Boundary wait: LOAD_REQ=1 while CPU_T1=0 for 5 cycles -> CPU_HALT=0 for those cycles, MEM_ADDR=CPU_ADDR; halt asserts the cycle after CPU_T1=1.
REQ-022 Abort in WAIT_T1: LOAD_REQ high 2 cycles then low, CPU_T1=0 -> return IDLE, no CPU_RST, LOAD_DONE=0.
REQ-023 Overrun: 18 valid bytes with LOAD_REQ held -> exactly 16 writes, byte 17/18 not written, no retrigger until LOAD_REQ low.
REQ-024 Reset mid-load: RST after 3 bytes -> all outputs at reset values same cycle, BYTE_CNT=0, no CPU_RST pulse.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: holds the CPU at an instruction boundary, streams host bytes
// into RAM, then releases the CPU with a one-cycle reset pulse.
module prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOAD_REQ,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  input  logic              CPU_T1,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_WE,
  output logic              CPU_HALT,
  output logic              CPU_RST,
  output logic              LOAD_DONE,
  output logic [ADDR_W:0]   BYTE_CNT
);

  typedef enum logic [1:0] {IDLE, WAIT_T1, LOAD, RELEASE} state_t;

  localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic              armed;
  logic              start;
  logic              wr;

  assign MEM_WDATA = DIN;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    wr        = 1'b0;
    MEM_ADDR  = CPU_ADDR;
    MEM_WE    = 1'b0;
    DIN_READY = 1'b0;
    CPU_HALT  = 1'b0;
    CPU_RST   = 1'b0;
    case (state)
      IDLE: begin
        if (LOAD_REQ && armed) begin
          state_nxt = WAIT_T1;
          start     = 1'b1;
        end
      end
      WAIT_T1: begin
        if (!LOAD_REQ) state_nxt = IDLE;
        else if (CPU_T1) state_nxt = LOAD;
      end
      LOAD: begin
        CPU_HALT  = 1'b1;
        DIN_READY = 1'b1;
        MEM_ADDR  = addr_cnt;
        MEM_WE    = DIN_VALID;
        wr        = DIN_VALID;
        // The byte that fills the RAM is written even if LOAD_REQ drops with it.
        if (!LOAD_REQ || (wr && BYTE_CNT == LAST_CNT)) state_nxt = RELEASE;
      end
      RELEASE: begin
        CPU_HALT  = 1'b1;
        CPU_RST   = 1'b1;
        MEM_ADDR  = addr_cnt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      BYTE_CNT  <= '0;
      LOAD_DONE <= 1'b0;
      armed     <= 1'b1;
    end else begin
      state <= state_nxt;
      if (start) begin
        addr_cnt  <= '0;
        BYTE_CNT  <= '0;
        LOAD_DONE <= 1'b0;
      end else if (wr) begin
        addr_cnt <= addr_cnt + ADDR_W'(1);
        BYTE_CNT <= BYTE_CNT + (ADDR_W+1)'(1);
      end
      if (state == RELEASE) LOAD_DONE <= 1'b1;
      // A held LOAD_REQ must be seen low in IDLE before the next load can start.
      if (state == RELEASE) armed <= 1'b0;
      else if (!LOAD_REQ) armed <= 1'b1;
    end
  end

endmodule
